scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
- Parametrised next-generation hazard unit for the 5-stage RISC-V core.
- Adds a scoreboard and a latency counter for one outstanding non-blocking multi-cycle (mul/div) operation, alongside the standard hazard logic: EX forwarding, load-use stall and taken-branch flush.
- Sits beside the control unit. Drives the F/D pipeline-register enables, the D/E flushes and the EX operand-forward selects.
- Also provides a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width; the scoreboard holds 2**REG_AW pending bits.
- MC_LAT, 4, multi-cycle unit latency in cycles; legal range 2..15.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d, rd_d  in  REG_AW each  source and destination registers in decode.
- regwrite_d  in  1  decode instruction writes rd.
- mc_d  in  1  decode instruction is a multi-cycle op.
- rs1_e, rs2_e, rd_e  in  REG_AW each  source and destination registers in EX.
- regwrite_e  in  1  EX instruction writes rd.
- load_e  in  1  EX instruction is a load (wbsel selects memory).
- mc_e  in  1  EX instruction is a multi-cycle op (issue).
- branch_taken_e  in  1  branch/jump in EX redirects the PC.
- rd_m, rd_w  in  REG_AW each  destination registers in MEM and WB.
- regwrite_m, regwrite_w  in  1 each  write enables in MEM and WB.
- en_f, en_d  out  1 each  PC and F/D register enables; 1 = advance.
- flush_d, flush_e  out  1 each  clear F/D and D/E registers.
- forward_ae, forward_be  out  2 each  EX operand selects: 00 regfile, 10 MEM, 01 WB.
- mc_busy  out  1  multi-cycle op in flight.
- mc_done  out  1  one-cycle result-valid pulse for the multi-cycle unit's write port.
- mc_rd  out  REG_AW  destination register of the in-flight op.
- stall_cycles  out  CNT_W  count of cycles with en_d=0.

Behaviour:
- Reset (async): state=IDLE, count=0, all pending bits 0, mc_rd=0, stall_cycles=0. Outputs take their combinational values for these register values.
- Forwarding (combinational), per source rsX_e:
  - Select MEM if regwrite_m and rd_m==rsX_e and rsX_e!=0.
  - Else select WB if regwrite_w and rd_w==rsX_e and rsX_e!=0.
  - Else 00.
  - MEM has priority over WB; x0 is never forwarded.
- Hazard terms (combinational); each register-compare term is qualified by a nonzero decode register:
  - lu: load_e and rd_e!=0 and rd_e in {rs1_d, rs2_d}.
  - mi: mc_e and rd_e!=0 and rd_e in {rs1_d, rs2_d}, or (regwrite_d and rd_d==rd_e).
  - sb: pending[rs1_d] or pending[rs2_d] or (regwrite_d and pending[rd_d]); x0 excluded.
  - sm: mc_d and (mc_busy or mc_e).
  - stall = lu | mi | sb | sm.
- Pipeline control:
  - en_f = en_d = ~stall.
  - flush_e = stall | branch_taken_e.
  - flush_d = branch_taken_e.
  - A branch flush overrides the stall for D; F and D enables still follow stall.
- FSM, states IDLE / BUSY:
  - IDLE with mc_e: go to BUSY; count<=MC_LAT-1; mc_rd<=rd_e; pending[rd_e]<=1 (unless rd_e==0).
  - BUSY with count!=0: count decrements by 1 per cycle.
  - BUSY with count==0: mc_done=1 this cycle. On the next edge, pending[mc_rd]<=0 and the FSM returns to IDLE.
  - The done cycle still stalls dependants; they read the regfile the following cycle.
  - mc_e while BUSY cannot occur because sm blocks it; a bench assertion flags it.
- Timing: mc_e at cycle t gives mc_done at cycle t+MC_LAT. mc_busy=(state==BUSY).
- stall_cycles increments each cycle stall=1 and saturates at all-ones.
- Reset mid-operation drops the in-flight op: no mc_done pulse and no pending bit survives.

Test Plan:
- Forwarding: regwrite_m=1, rd_m=5; regwrite_w=1, rd_w=5; rs1_e=5, rs2_e=0 -> forward_ae=10 (MEM wins), forward_be=00. Then rd_m=3 -> forward_ae=01.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> en_f=en_d=0, flush_e=1 for one cycle, stall_cycles +1. Same case with rd_e=0 -> no stall.
- Branch: branch_taken_e=1 with no hazard -> flush_d=flush_e=1, en_f=en_d=1. Branch together with a load-use hazard -> flush_d=1, en_d=0.
- Multi-cycle, MC_LAT=4: mc_e=1, rd_e=9 at cycle 0 -> mc_busy cycles 1..4, mc_done=1 only in cycle 4 with mc_rd=9. Decode rs1_d=9 stalls through cycle 4 and is released in cycle 5. Independent rs1_d=3 never stalls.
- Structural and WAW: mc_d=1 while busy -> stall until IDLE. regwrite_d=1 with rd_d==pending rd -> stall.
- Reset at cycle 2 of a multi-cycle op -> mc_busy=0, no mc_done, pending cleared, stall_cycles=0 immediately (asynchronously).

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: forwarding, load-use/branch hazards and a one-entry multi-cycle scoreboard
module scoreboard_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              mc_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              load_e,
    input  logic              mc_e,
    input  logic              branch_taken_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic              en_f,
    output logic              en_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [REG_AW-1:0] mc_rd,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nx;
    logic [3:0]        count, count_nx;
    logic [NREG-1:0]   pending, pending_nx;
    logic [REG_AW-1:0] mc_rd_nx;
    logic              lu, mi, sb, sm, stall;
    logic              unused_regwrite_e;

    // The EX write enable is implied by load_e/mc_e for every hazard term.
    assign unused_regwrite_e = regwrite_e;

    assign forward_ae = (regwrite_m && rd_m == rs1_e && rs1_e != '0) ? 2'b10 :
                        (regwrite_w && rd_w == rs1_e && rs1_e != '0) ? 2'b01 : 2'b00;
    assign forward_be = (regwrite_m && rd_m == rs2_e && rs2_e != '0) ? 2'b10 :
                        (regwrite_w && rd_w == rs2_e && rs2_e != '0) ? 2'b01 : 2'b00;

    // Stall sources: load-use, multi-cycle issue dependants, scoreboard hits, structural
    always_comb begin
        lu    = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
        mi    = mc_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d || (regwrite_d && rd_d == rd_e));
        sb    = (rs1_d != '0 && pending[rs1_d]) || (rs2_d != '0 && pending[rs2_d]) ||
                (regwrite_d && rd_d != '0 && pending[rd_d]);
        sm    = mc_d && (state == BUSY || mc_e);
        stall = lu || mi || sb || sm;
    end

    assign en_f    = !stall;
    assign en_d    = !stall;
    assign flush_e = stall || branch_taken_e;
    assign flush_d = branch_taken_e;
    assign mc_busy = state == BUSY;
    assign mc_done = state == BUSY && count == '0;

    // Next state of the multi-cycle tracker: issue, count down, retire
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        pending_nx = pending;
        mc_rd_nx   = mc_rd;
        if (state == IDLE && mc_e) begin
            state_nx = BUSY;
            count_nx = 4'(MC_LAT - 1);
            mc_rd_nx = rd_e;
            if (rd_e != '0) pending_nx[rd_e] = 1'b1;
        end else if (state == BUSY && count != '0) begin
            count_nx = count - 4'd1;
        end else if (state == BUSY) begin
            pending_nx[mc_rd] = 1'b0;
            state_nx          = IDLE;
        end
    end

    // Tracker registers and the saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            pending      <= '0;
            mc_rd        <= '0;
            stall_cycles <= '0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            pending <= pending_nx;
            mc_rd   <= mc_rd_nx;
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed stimulus checked against a timeline model of the hazard unit
module tb_scoreboard_hazard_unit;
    localparam int MC_LAT = 4;

    logic       clk = 0, reset = 1;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_d, mc_d, regwrite_e, load_e, mc_e, branch_taken_e, regwrite_m, regwrite_w;
    logic       en_f, en_d, flush_d, flush_e, mc_busy, mc_done;
    logic [1:0] forward_ae, forward_be;
    logic [4:0] mc_rd;
    logic [31:0] stall_cycles;

    int tests = 0, fails = 0;
    int cyc = 0, issue_at = -1;
    logic [4:0]  m_rd = 0;
    logic [31:0] exp_stall = 0;

    scoreboard_hazard_unit #(.REG_AW(5), .MC_LAT(MC_LAT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .mc_d(mc_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .load_e(load_e), .mc_e(mc_e), .branch_taken_e(branch_taken_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .en_f(en_f), .en_d(en_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_ae(forward_ae), .forward_be(forward_be), .mc_busy(mc_busy),
        .mc_done(mc_done), .mc_rd(mc_rd), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        return issue_at >= 0 && cyc > issue_at && cyc <= issue_at + MC_LAT;
    endfunction

    function automatic bit m_done();
        return issue_at >= 0 && cyc == issue_at + MC_LAT;
    endfunction

    function automatic bit m_pend(input logic [4:0] r);
        return r != 0 && m_busy() && r == m_rd;
    endfunction

    function automatic bit hit(input logic [4:0] r);
        return r != 0 && (r == rs1_d || r == rs2_d);
    endfunction

    function automatic bit m_stall();
        bit lu, mi, sb, sm;
        lu = load_e && hit(rd_e);
        mi = mc_e && rd_e != 0 && (hit(rd_e) || (regwrite_d && rd_d == rd_e));
        sb = m_pend(rs1_d) || m_pend(rs2_d) || (regwrite_d && m_pend(rd_d));
        sm = mc_d && (m_busy() || mc_e);
        return lu || mi || sb || sm;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (regwrite_m && rd_m == r && r != 0) return 2'b10;
        if (regwrite_w && rd_w == r && r != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endtask

    // Model timeline: an issue at cycle c is busy in c+1..c+MC_LAT and done at c+MC_LAT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_at = -1;
            m_rd = 0;
            exp_stall = 0;
        end else begin
            if (m_stall() && exp_stall != 32'hffff_ffff) exp_stall++;
            if (mc_e && !m_busy()) begin
                issue_at = cyc;
                m_rd = rd_e;
            end
            cyc++;
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(mc_e && m_busy())) else $error("mc_e issued while busy");
            chk("en_f", en_f, !m_stall());
            chk("en_d", en_d, !m_stall());
            chk("flush_e", flush_e, m_stall() || branch_taken_e);
            chk("flush_d", flush_d, branch_taken_e);
            chk("forward_ae", forward_ae, m_fwd(rs1_e));
            chk("forward_be", forward_be, m_fwd(rs2_e));
            chk("mc_busy", mc_busy, m_busy());
            chk("mc_done", mc_done, m_done());
            chk("mc_rd", mc_rd, m_rd);
            chk("stall_cycles", stall_cycles, exp_stall);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {regwrite_d, mc_d, regwrite_e, load_e, mc_e, branch_taken_e, regwrite_m, regwrite_w} = '0;
    endtask

    initial begin
        clr();
        #3;
        chk("rst en_d", en_d, 1);
        chk("rst mc_busy", mc_busy, 0);
        chk("rst stall_cycles", stall_cycles, 0);
        tick();
        tick();
        reset = 0;
        // forwarding: MEM beats WB, x0 never forwarded
        regwrite_m = 1; rd_m = 5; regwrite_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 0;
        #1;
        chk("fwd mem", forward_ae, 2'b10);
        chk("fwd x0", forward_be, 2'b00);
        tick();
        rd_m = 3;
        #1;
        chk("fwd wb", forward_ae, 2'b01);
        tick();
        // load-use
        clr();
        load_e = 1; regwrite_e = 1; rd_e = 7; rs2_d = 7;
        #1;
        chk("lu en_d", en_d, 0);
        chk("lu flush_e", flush_e, 1);
        tick();
        clr();
        #1;
        chk("lu count", stall_cycles, 1);
        load_e = 1; regwrite_e = 1; rd_e = 0; rs2_d = 0;
        #1;
        chk("lu x0 en_d", en_d, 1);
        tick();
        // branch alone and with a load-use hazard
        clr();
        branch_taken_e = 1;
        #1;
        chk("br flush_d", flush_d, 1);
        chk("br flush_e", flush_e, 1);
        chk("br en_d", en_d, 1);
        tick();
        load_e = 1; rd_e = 7; rs1_d = 7;
        #1;
        chk("br+lu flush_d", flush_d, 1);
        chk("br+lu en_d", en_d, 0);
        tick();
        // multi-cycle op to x9, independent decode in the issue cycle
        clr();
        mc_e = 1; regwrite_e = 1; rd_e = 9; rs1_d = 3;
        #1;
        chk("mc0 en_d", en_d, 1);
        tick();
        clr();
        rs1_d = 9;
        for (int k = 1; k <= MC_LAT; k++) begin
            #1;
            chk("mc busy", mc_busy, 1);
            chk("mc done", mc_done, k == MC_LAT);
            chk("mc rd", mc_rd, 9);
            chk("mc dep stall", en_d, 0);
            tick();
        end
        #1;
        chk("mc released", en_d, 1);
        chk("mc idle", mc_busy, 0);
        tick();
        // structural: independent decode passes, mc_d waits until idle
        clr();
        mc_e = 1; regwrite_e = 1; rd_e = 10;
        tick();
        clr();
        rs1_d = 3;
        #1;
        chk("indep", en_d, 1);
        tick();
        mc_d = 1; rd_d = 11; regwrite_d = 1;
        repeat (4) tick();
        #1;
        chk("struct released", en_d, 1);
        tick();
        // WAW against the pending destination
        clr();
        mc_e = 1; regwrite_e = 1; rd_e = 12;
        tick();
        clr();
        regwrite_d = 1; rd_d = 12;
        #1;
        chk("waw stall", en_d, 0);
        tick();
        rd_d = 13;
        #1;
        chk("waw other", en_d, 1);
        repeat (4) tick();
        // asynchronous reset in cycle 2 of an op
        clr();
        mc_e = 1; regwrite_e = 1; rd_e = 9;
        tick();
        clr();
        rs1_d = 9;
        tick();
        reset = 1;
        #1;
        chk("rstmid busy", mc_busy, 0);
        chk("rstmid done", mc_done, 0);
        chk("rstmid pending", en_d, 1);
        chk("rstmid count", stall_cycles, 0);
        tick();
        reset = 0;
        repeat (6) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
